// File: rtl/fp8_result_packer_if.sv
// rtl/fp8_result_packer_if.sv - result field input and packed word output stream bundle for fp8_result_packer
interface fp8_result_packer_if #(
    parameter int EXP_WIDTH  = 3,
    parameter int MANT_WIDTH = 4,
    parameter int WIDTH      = 1 + EXP_WIDTH + MANT_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [MANT_WIDTH-1:0] in_mant;
    logic                  in_nan;
    logic                  in_inf;
    logic                  in_zero;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;

    // Producer of result fields and consumer of packed words
    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    // The packer itself
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero,
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/fp8_result_packer.sv
// rtl/fp8_result_packer.sv - FP8 result encoder with output FIFO and sticky exception status (option macro FP8_PACK_CANON_NAN_EN)
module fp8_result_packer #(
    parameter int WIDTH      = 8,
    parameter int EXP_WIDTH  = 3,
    parameter int MANT_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fp8_result_packer_if.slave   bus,
    output logic [2:0]           sticky,
    input  logic                 sticky_clr
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [EXP_WIDTH-1:0]  EXP_MAX   = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = '0;
    localparam logic [MANT_WIDTH-1:0] MANT_MAX  = {MANT_WIDTH{1'b1}};
    localparam logic [MANT_WIDTH-1:0] MANT_ZERO = '0;

    // Sticky bit positions: {nan, inf, zero}
    localparam logic [2:0] CLS_NAN  = 3'b100;
    localparam logic [2:0] CLS_INF  = 3'b010;
    localparam logic [2:0] CLS_ZERO = 3'b001;
    localparam logic [2:0] CLS_NORM = 3'b000;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] enc_word;
    logic [2:0]       enc_class;
    logic             nan_sign;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

`ifdef FP8_PACK_CANON_NAN_EN
    assign nan_sign = 1'b0;
`else
    assign nan_sign = bus.in_sign;
`endif

    // Encode the result fields; a normal result whose exponent saturates becomes Inf so the
    // all-ones exponent only ever leaves as a flagged Inf or NaN.
    always_comb begin
        enc_word  = {bus.in_sign, bus.in_exp, bus.in_mant};
        enc_class = CLS_NORM;
        if (bus.in_nan) begin
            enc_word  = {nan_sign, EXP_MAX, MANT_MAX};
            enc_class = CLS_NAN;
        end else if (bus.in_inf) begin
            enc_word  = {bus.in_sign, EXP_MAX, MANT_ZERO};
            enc_class = CLS_INF;
        end else if (bus.in_zero) begin
            enc_word  = {bus.in_sign, EXP_ZERO, MANT_ZERO};
            enc_class = CLS_ZERO;
        end else if (bus.in_exp == EXP_MAX) begin
            enc_word  = {bus.in_sign, EXP_MAX, MANT_ZERO};
            enc_class = CLS_INF;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign sticky        = sticky_q;

    // Next pointer and sticky state; clear beats a same-cycle exception push
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        sticky_d = sticky_q | (push ? enc_class : 3'b000);
        if (sticky_clr) begin
            sticky_d = 3'b000;
        end
    end

    // Pointer and sticky registers; reset empties the FIFO at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
        end
    end

    // Word storage; contents are invisible while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
        end
    end
endmodule

// File: tb/tb_fp8_result_packer.sv
// tb/tb_fp8_result_packer.sv - self-checking bench for fp8_result_packer
module tb_fp8_result_packer;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] sticky;
    logic       sticky_clr;

    int checks;
    int errors;

    logic [7:0] mq[$];
    logic [2:0] msticky;

`ifdef FP8_PACK_CANON_NAN_EN
    localparam logic [7:0] NAN_NEG = 8'h7F;
`else
    localparam logic [7:0] NAN_NEG = 8'hFF;
`endif

    fp8_result_packer_if bus_if ();

    fp8_result_packer #(.WIDTH(8), .EXP_WIDTH(3), .MANT_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .sticky     (sticky),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model_encode(input logic s, input logic [2:0] e, input logic [3:0] m,
                                         input logic n, input logic i, input logic z,
                                         output logic [7:0] w, output logic [2:0] c);
        if (n) begin
`ifdef FP8_PACK_CANON_NAN_EN
            w = 8'h7F;
`else
            w = {s, 7'h7F};
`endif
            c = 3'b100;
        end else if (i) begin
            w = {s, 7'h70};
            c = 3'b010;
        end else if (z) begin
            w = {s, 7'h00};
            c = 3'b001;
        end else if (e == 3'd7) begin
            w = {s, 7'h70};
            c = 3'b010;
        end else begin
            w = {s, e, m};
            c = 3'b000;
        end
    endfunction

    task automatic compare_all();
        logic [7:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
        check("out_valid", {7'b0, bus_if.out_valid}, {7'b0, mq.size() != 0});
        check("in_ready", {7'b0, bus_if.in_ready}, {7'b0, mq.size() < DEPTH});
        check("out_data", bus_if.out_data, exp_data);
        check("sticky", {5'b0, sticky}, {5'b0, msticky});
    endtask

    // One clock: drive at the falling edge, let the model follow the rising edge, compare at the next falling edge
    task automatic step(input logic v, input logic s, input logic [2:0] e, input logic [3:0] m,
                        input logic n, input logic i, input logic z, input logic ordy, input logic clr);
        logic [7:0] w;
        logic [2:0] c;
        logic       acc;
        logic       pp;
        bus_if.in_valid  = v;
        bus_if.in_sign   = s;
        bus_if.in_exp    = e;
        bus_if.in_mant   = m;
        bus_if.in_nan    = n;
        bus_if.in_inf    = i;
        bus_if.in_zero   = z;
        bus_if.out_ready = ordy;
        sticky_clr       = clr;
        @(posedge clk);
        if (!rst) begin
            model_encode(s, e, m, n, i, z, w, c);
            acc = v && (mq.size() < DEPTH);
            pp  = ordy && (mq.size() != 0);
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(w);
            if (clr) msticky = 3'b000;
            else if (acc) msticky = msticky | c;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_word(input logic [7:0] w, input logic ordy);
        step(1'b1, w[7], w[6:4], w[3:0], 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy, input logic clr);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, ordy, clr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        msticky = 3'b000;
        rst = 1'b1;
        sticky_clr = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_sign = 1'b0;
        bus_if.in_exp = 3'd0;
        bus_if.in_mant = 4'd0;
        bus_if.in_nan = 1'b0;
        bus_if.in_inf = 1'b0;
        bus_if.in_zero = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        #1;
        check("reset_in_ready", {7'b0, bus_if.in_ready}, 8'h01);
        check("reset_out_data", bus_if.out_data, 8'h00);
        @(negedge clk);

        // Normal encode and one-cycle latency
        step(1'b1, 1'b1, 3'b011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("normal_word", bus_if.out_data, 8'hB5);
        check("normal_valid", {7'b0, bus_if.out_valid}, 8'h01);
        check("normal_sticky", {5'b0, sticky}, 8'h00);
        idle(1'b1, 1'b0);

        // Exception priority
        step(1'b1, 1'b1, 3'b010, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("nan_prio_word", bus_if.out_data, NAN_NEG);
        check("nan_prio_sticky", {5'b0, sticky}, 8'h04);
        step(1'b1, 1'b0, 3'b001, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("inf_word", bus_if.out_data, 8'h70);
        step(1'b1, 1'b1, 3'b101, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("zero_word", bus_if.out_data, 8'h80);
        step(1'b1, 1'b0, 3'b111, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("exp_sat_word", bus_if.out_data, 8'h70);
        check("exp_sat_sticky", {5'b0, sticky}, 8'h07);
        idle(1'b1, 1'b1);
        check("sticky_cleared", {5'b0, sticky}, 8'h00);

        // Backpressure: fifth word refused, drain in order, head stable while stalled
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b0);
        push_word(8'h44, 1'b0);
        check("full_in_ready", {7'b0, bus_if.in_ready}, 8'h00);
        push_word(8'h55, 1'b0);
        check("stall_head", bus_if.out_data, 8'h11);
        idle(1'b0, 1'b0);
        check("stall_head_hold", bus_if.out_data, 8'h11);
        idle(1'b1, 1'b0);
        check("drain_2", bus_if.out_data, 8'h22);
        idle(1'b1, 1'b0);
        check("drain_3", bus_if.out_data, 8'h33);
        idle(1'b1, 1'b0);
        check("drain_4", bus_if.out_data, 8'h44);
        idle(1'b1, 1'b0);
        check("drain_empty", {7'b0, bus_if.out_valid}, 8'h00);

        // Full with push and pop together: only the pop happens
        push_word(8'h01, 1'b0);
        push_word(8'h02, 1'b0);
        push_word(8'h03, 1'b0);
        push_word(8'h04, 1'b0);
        push_word(8'h66, 1'b1);
        check("full_pop_in_ready", {7'b0, bus_if.in_ready}, 8'h01);
        check("full_pop_head", bus_if.out_data, 8'h02);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("full_pop_last", bus_if.out_data, 8'h04);
        idle(1'b1, 1'b0);
        check("full_pop_empty", {7'b0, bus_if.out_valid}, 8'h00);

        // Level two with push and pop together
        push_word(8'h0A, 1'b0);
        push_word(8'h0B, 1'b0);
        push_word(8'h0C, 1'b1);
        check("lvl2_head", bus_if.out_data, 8'h0B);
        idle(1'b1, 1'b0);
        check("lvl2_next", bus_if.out_data, 8'h0C);
        idle(1'b1, 1'b0);

        // Sticky clear beats a same-cycle NaN push, word still enqueued
        step(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("race_pre_sticky", {5'b0, sticky}, 8'h02);
        step(1'b1, 1'b1, 3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("race_sticky", {5'b0, sticky}, 8'h00);
        check("race_word", bus_if.out_data, NAN_NEG);
        idle(1'b1, 1'b0);

        // Asynchronous reset with three words buffered
        push_word(8'h21, 1'b0);
        push_word(8'h31, 1'b0);
        push_word(8'h41, 1'b0);
        idle(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        mq.delete();
        msticky = 3'b000;
        #1;
        check("async_rst_valid", {7'b0, bus_if.out_valid}, 8'h00);
        check("async_rst_sticky", {5'b0, sticky}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {7'b0, bus_if.in_ready}, 8'h01);
        @(negedge clk);
        idle(1'b1, 1'b0);
        push_word(8'h12, 1'b0);
        check("post_rst_word", bus_if.out_data, 8'h12);
        idle(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp8_result_packer.md
Name: fp8_result_packer

Overview:
- Output-side encoder for the FP8 MAC datapath: sign 1, exponent 3, mantissa 4, 8 bits total.
- Accepts the normalized result fields (sign, exponent, mantissa) and the NaN/Inf/zero exception decisions produced by the add/multiply pipeline.
- Encodes each result into a packed 8-bit word, which is the inverse of the operand flag decode.
- Buffers words in a small FIFO and streams them out to the result drain with a valid/ready handshake, keeping sticky exception status.

Parameters:
- WIDTH, 8, packed word width
- EXP_WIDTH, 3, exponent field width
- MANT_WIDTH, 4, mantissa field width (WIDTH = 1+EXP_WIDTH+MANT_WIDTH)
- DEPTH, 4, FIFO entries; power of 2, minimum 2

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  result fields valid
- in_ready  output  1  packer can accept
- in_sign  input  1  result sign
- in_exp  input  EXP_WIDTH  normalized exponent
- in_mant  input  MANT_WIDTH  normalized mantissa, hidden bit excluded
- in_nan  input  1  NaN decision
- in_inf  input  1  Inf decision (includes exponent overflow)
- in_zero  input  1  zero/underflow decision
- out_valid  output  1  FIFO head valid
- out_ready  input  1  drain accepts head
- out_data  output  WIDTH  packed word at FIFO head
- sticky  output  3  {nan_seen, inf_seen, zero_seen}
- sticky_clr  input  1  synchronous clear of sticky

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - FIFO empty; read and write pointers 0.
  - out_valid=0, out_data=0, sticky=0.
  - in_ready=1 once rst deasserts.
- Encoding is combinational at the FIFO write side. Priority is NaN > Inf > zero > normal:
  - NaN: {in_sign, 111, 1111}.
  - Inf: {in_sign, 111, 0000}.
  - zero: {in_sign, 000, 0000}.
  - normal: {in_sign, in_exp, in_mant}.
  - Normal path with in_exp==111: encoded as Inf and treated as Inf for sticky. Never emits an unflagged NaN pattern.
- Push: in_valid & in_ready. in_ready = ~full. It is not combinationally dependent on out_ready; no bypass.
- Pop: out_valid & out_ready. out_valid = ~empty. out_data = head entry, registered storage.
- Latency: a word pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1 at earliest.
- Full/empty: pointers carry one extra wrap bit.
  - full when pointer bits are equal and wrap bits differ.
  - empty when both are equal.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop (neither full nor empty): both occur and occupancy is unchanged.
- When full: no push that cycle, even if a pop occurs. in_ready rises the cycle after the pop.
- When empty: a push still occurs. out_valid stays 0 that cycle and goes to 1 the next.
- out_data holds stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO.
- Sticky update on each push ORs in the effective class: nan_seen, inf_seen (including the exp==111 case), zero_seen.
- sticky_clr wins over a same-cycle set: sticky becomes 0 that edge, and the concurrent push's class is lost.
- in_* values are ignored when in_valid=0 or in_ready=0.
- Reset mid-stream discards all buffered words immediately; no partial output.

Optional Feature:
- Macro: FP8_PACK_CANON_NAN_EN.
- Defined: every NaN encodes as canonical 0x7F (sign forced to 0).
- Undefined: NaN keeps the input sign, giving 0x7F or 0xFF.
- All other behaviour is identical either way.

Test Plan:
- Normal encode and latency:
  - Stimulus: push sign=1, exp=011, mant=0101, out_ready=1.
  - Response: out_data=0xB5 with out_valid=1 on the next cycle; sticky=000.
- Exception priority:
  - Stimulus: push sign=1 with nan=inf=zero=1.
  - Response: 0xFF without macro, 0x7F with macro; sticky=100.
  - Stimulus: push inf=1, sign=0.
  - Response: 0x70.
  - Stimulus: push zero=1, sign=1.
  - Response: 0x80.
  - Stimulus: push normal path with exp=111, mant=0011.
  - Response: 0x70 and inf_seen=1.
- Backpressure (DEPTH=4):
  - Stimulus: out_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 in successive cycles.
  - Response: in_ready=0 after the 4th push and 0x55 is not accepted. Raising out_ready drains 0x11, 0x22, 0x33, 0x44 in order; out_data stays stable while stalled.
- Concurrent push/pop:
  - Stimulus: level=2, push and pop in the same cycle.
  - Response: level stays 2 and order is preserved.
  - Stimulus: FIFO full, push and pop in the same cycle.
  - Response: the pop only occurs; in_ready=1 on the next cycle.
- Sticky clear race:
  - Stimulus: sticky=010, then a cycle with sticky_clr=1 and a NaN push.
  - Response: sticky=000 next cycle; the word is still enqueued.
- Reset mid-operation:
  - Stimulus: 3 words buffered, assert rst asynchronously between edges.
  - Response: out_valid=0 and sticky=000 immediately; after release, in_ready=1 and the FIFO is empty.
